// File: rtl/des_cbc_sequencer.sv
// Block sequencer for a DES core: accepts 64-bit blocks over valid/ready, applies CBC
// (or ECB) chaining around one core operation per block, and returns the result.
module des_cbc_sequencer #(
    parameter int CBC_EN         = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_load,
    input  logic        cfg_encrypt,
    input  logic [63:0] cfg_key,
    input  logic [63:0] cfg_iv,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy,
    output logic        err,
    output logic        core_start,
    output logic        core_encrypt,
    output logic [63:0] core_key,
    output logic [63:0] core_data_in,
    input  logic [63:0] core_data_out,
    input  logic        core_done,
    input  logic        core_error
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUT,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic          live_q;
    logic [63:0]   key_q, key_d;
    logic          mode_q, mode_d;
    logic [63:0]   chain_q, chain_d;
    logic [63:0]   ct_save_q, ct_save_d;
    logic [63:0]   core_data_in_q, core_data_in_d;
    logic [63:0]   out_data_q, out_data_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            live_q         <= 1'b0;
            key_q          <= '0;
            mode_q         <= 1'b1;
            chain_q        <= '0;
            ct_save_q      <= '0;
            core_data_in_q <= '0;
            out_data_q     <= '0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            live_q         <= 1'b1;
            key_q          <= key_d;
            mode_q         <= mode_d;
            chain_q        <= chain_d;
            ct_save_q      <= ct_save_d;
            core_data_in_q <= core_data_in_d;
            out_data_q     <= out_data_d;
            cnt_q          <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        key_d          = key_q;
        mode_d         = mode_q;
        chain_d        = chain_q;
        ct_save_d      = ct_save_q;
        core_data_in_d = core_data_in_q;
        out_data_d     = out_data_q;
        cnt_d          = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_load) begin
                    key_d   = cfg_key;
                    mode_d  = cfg_encrypt;
                    chain_d = cfg_iv;
                end
                // Handshake uses the freshly loaded mode/IV when cfg_load coincides.
                if (in_valid && live_q) begin
                    ct_save_d = in_data;
                    if (mode_d && (CBC_EN != 0)) begin
                        core_data_in_d = in_data ^ chain_d;
                    end else begin
                        core_data_in_d = in_data;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // The first WAIT cycle ignores done so a level-held done from the
                // previous operation cannot complete this one.
                if (core_done && (cnt_q != '0)) begin
                    if (core_error) begin
                        state_d = S_ERR;
                    end else begin
                        if (mode_q) begin
                            out_data_d = core_data_out;
                            chain_d    = core_data_out;
                        end else begin
                            out_data_d = (CBC_EN != 0) ? (core_data_out ^ chain_q) : core_data_out;
                            chain_d    = ct_save_q;
                        end
                        state_d = S_OUT;
                    end
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_ERR;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                if (cfg_load) begin
                    key_d   = cfg_key;
                    mode_d  = cfg_encrypt;
                    chain_d = cfg_iv;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready     = (state_q == S_IDLE) && live_q;
    assign out_valid    = (state_q == S_OUT);
    assign out_data     = out_data_q;
    assign busy         = (state_q != S_IDLE) && (state_q != S_ERR);
    assign err          = (state_q == S_ERR);
    assign core_start   = (state_q == S_ISSUE);
    assign core_encrypt = mode_q;
    assign core_key     = key_q;
    assign core_data_in = core_data_in_q;

endmodule
